// File: rtl/edge_detect_pkg.sv
// Shared types for the multi-channel edge detector.
// Latency: n/a (types, constants and a decode helper only).
// Backpressure: n/a.
package edge_detect_pkg;

  // Edge FSM states. RISE and FALL are one-cycle states in which a tick is
  // emitted.
  typedef enum logic [1:0] {
    LOW  = 2'b00,
    RISE = 2'b01,
    HIGH = 2'b11,
    FALL = 2'b10
  } state_t;

  // Per-channel mode select. Bit 0 enables rising ticks and bit 1 enables
  // falling ticks.
  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_RISE = 2'b01;
  localparam logic [1:0] MODE_FALL = 2'b10;
  localparam logic [1:0] MODE_BOTH = 2'b11;

  // Moore tick decode. The result depends only on state and mode, so a mode
  // change takes effect in the same cycle.
  function automatic logic tick_of(input state_t st, input logic [1:0] mode);
    logic hit_rise;
    logic hit_fall;
    hit_rise = (st == RISE) && ((mode & MODE_RISE) != MODE_OFF);
    hit_fall = (st == FALL) && ((mode & MODE_FALL) != MODE_OFF);
    return hit_rise || hit_fall;
  endfunction

endpackage

// File: rtl/edge_chan.sv
// One channel: optional 2-flop synchroniser, debounce counter, Moore edge FSM, sticky pending.
// Latency: input stable before edge k -> tick in the cycle after edge k+(SYNC_EN?2:0)+DEB_CYCLES.
// Backpressure: none; ticks are fire-and-forget, and pending holds them until clr.
module edge_chan
  import edge_detect_pkg::*;
#(
  parameter int DEB_CYCLES = 1,
  parameter int SYNC_EN    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       level,
  input  logic [1:0] mode,
  input  logic       clr,
  output logic       tick,
  output logic       level_f,
  output logic       pending
);

  localparam int             CW       = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          s;
  logic [CW-1:0] cnt;
  logic          acc;
  state_t        state_q;
  state_t        state_d;

  generate
    if (SYNC_EN != 0) begin : g_sync
      logic [1:0] sync_q;
      // Two-flop synchroniser for the asynchronous input level.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_q <= 2'b00;
        else       sync_q <= {sync_q[0], level};
      end
      assign s = sync_q[1];
    end else begin : g_nosync
      assign s = level;
    end
  endgenerate

  // Debounce: count cycles in which s differs from the accepted level, and
  // register a one-cycle accept once DEB_CYCLES such cycles run back to back.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      acc <= 1'b0;
    end else if (s == level_f) begin
      cnt <= '0;
      acc <= 1'b0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
      acc <= 1'b1;
    end else begin
      cnt <= cnt + CW'(1);
      acc <= 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= LOW;
    else       state_q <= state_d;
  end

  // Next state. RISE and FALL always advance, so a stale accept that arrives
  // while the FSM is in one of them is absorbed.
  always_comb begin
    state_d = state_q;
    case (state_q)
      LOW:     if (acc) state_d = RISE;
      RISE:    state_d = HIGH;
      HIGH:    if (acc) state_d = FALL;
      FALL:    state_d = LOW;
      default: state_d = LOW;
    endcase
  end

  // Moore outputs: the filtered level and the mode-gated tick.
  always_comb begin
    level_f = (state_q == RISE) || (state_q == HIGH);
    tick    = tick_of(state_q, mode);
  end

  // Sticky pending flag. When tick and clr arrive in the same cycle, the set
  // wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pending <= 1'b0;
    else       pending <= (pending & ~clr) | tick;
  end

endmodule

// File: rtl/edge_detect_multi.sv
// Multi-channel synchronise/debounce/edge-detect block with sticky per-channel pending flags.
// Latency: tick follows edge k+(SYNC_EN?2:0)+DEB_CYCLES for an input that is stable before edge k.
// Backpressure: none; pending holds each event until software pulses clr.
module edge_detect_multi
  import edge_detect_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int DEB_CYCLES = 1,
  parameter int SYNC_EN    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_CH-1:0]   level,
  input  logic [2*N_CH-1:0] mode,
  input  logic [N_CH-1:0]   clr,
  output logic [N_CH-1:0]   tick,
  output logic [N_CH-1:0]   level_f,
  output logic [N_CH-1:0]   pending,
  output logic              any_pending
);

  generate
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
      edge_chan #(
        .DEB_CYCLES(DEB_CYCLES),
        .SYNC_EN   (SYNC_EN)
      ) u_chan (
        .clk    (clk),
        .reset  (reset),
        .level  (level[i]),
        .mode   (mode[2*i +: 2]),
        .clr    (clr[i]),
        .tick   (tick[i]),
        .level_f(level_f[i]),
        .pending(pending[i])
      );
    end
  endgenerate

  // Summary interrupt: set while any channel has a pending event.
  always_comb begin
    any_pending = |pending;
  end

endmodule

// File: tb/tb_edge_detect_multi.sv
// Scoreboard bench: two DUTs (DEB_CYCLES 1 and 4) share clock and reset.
// Expected ticks are queued when stimulus is applied, and a negedge monitor
// pops and checks each one.
module tb_edge_detect_multi;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] level_a, clr_a, tick_a, lf_a, pend_a;
  logic [7:0] mode_a;
  logic       any_a;
  logic [3:0] level_b, clr_b, tick_b, lf_b, pend_b;
  logic [7:0] mode_b;
  logic       any_b;

  always #5 clk = ~clk;

  edge_detect_multi #(.N_CH(4), .DEB_CYCLES(1), .SYNC_EN(1)) dut_a (
    .clk(clk), .reset(reset), .level(level_a), .mode(mode_a), .clr(clr_a),
    .tick(tick_a), .level_f(lf_a), .pending(pend_a), .any_pending(any_a)
  );

  edge_detect_multi #(.N_CH(4), .DEB_CYCLES(4), .SYNC_EN(1)) dut_b (
    .clk(clk), .reset(reset), .level(level_b), .mode(mode_b), .clr(clr_b),
    .tick(tick_b), .level_f(lf_b), .pending(pend_b), .any_pending(any_b)
  );

  // Cycle number: during cycle N (between edge N and edge N+1) cyc == N.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int         cyc;
    logic [3:0] tick;
    logic [3:0] lvl;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb;
  int   x;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: every nonzero tick must match the head of its DUT's queue.
  always @(negedge clk) begin
    if (tick_a !== 4'b0000) begin
      if (q_a.size() == 0) begin
        chk("a_unexpected_tick", {28'd0, tick_a}, 32'd0);
      end else begin
        ea = q_a.pop_front();
        chk("a_tick_cycle", cyc, ea.cyc);
        chk("a_tick_vec", {28'd0, tick_a}, {28'd0, ea.tick});
        chk("a_tick_level_f", {28'd0, lf_a & ea.tick}, {28'd0, ea.lvl});
      end
    end
    if (tick_b !== 4'b0000) begin
      if (q_b.size() == 0) begin
        chk("b_unexpected_tick", {28'd0, tick_b}, 32'd0);
      end else begin
        eb = q_b.pop_front();
        chk("b_tick_cycle", cyc, eb.cyc);
        chk("b_tick_vec", {28'd0, tick_b}, {28'd0, eb.tick});
        chk("b_tick_level_f", {28'd0, lf_b & eb.tick}, {28'd0, eb.lvl});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b1;
    level_a = 4'h0; mode_a = 8'h55; clr_a = 4'h0;
    level_b = 4'h0; mode_b = 8'hFF; clr_b = 4'h0;
    repeat (3) @(negedge clk);
    chk("rst_a_tick", tick_a, 0);  chk("rst_a_lvlf", lf_a, 0);
    chk("rst_a_pend", pend_a, 0);  chk("rst_a_any", any_a, 0);
    chk("rst_b_tick", tick_b, 0);  chk("rst_b_lvlf", lf_b, 0);
    chk("rst_b_pend", pend_b, 0);  chk("rst_b_any", any_b, 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // A: rising step on ch0 with mode 01 on every channel. The latency is 1+2+DEB = 4.
    x = cyc; level_a[0] = 1'b1;
    q_a.push_back('{x + 4, 4'b0001, 4'b0001});
    wait_cyc(x + 3); chk("a_lvlf_before", lf_a, 4'b0000);
    wait_cyc(x + 4); chk("a_lvlf_at_tick", lf_a, 4'b0001); chk("a_pend_at_tick", pend_a, 0);
    wait_cyc(x + 5); chk("a_pend_set", pend_a, 4'b0001); chk("a_any_set", any_a, 1);
    clr_a = 4'b0001;
    wait_cyc(x + 6); clr_a = 4'b0000;
    chk("a_pend_clr", pend_a, 0); chk("a_any_clr", any_a, 0);

    // A: the falling edge on ch0 is masked by mode 01, but level_f still tracks it.
    x = cyc; level_a[0] = 1'b0;
    wait_cyc(x + 8); chk("a_fall_masked_lvlf", lf_a, 0); chk("a_fall_masked_pend", pend_a, 0);

    // A: ch2 in falling-only mode. The rise is silent and the fall ticks.
    mode_a[5:4] = 2'b10;
    x = cyc; level_a[2] = 1'b1;
    wait_cyc(x + 4); chk("a_ch2_lvlf_up", lf_a, 4'b0100);
    wait_cyc(x + 6); level_a[2] = 1'b0;
    q_a.push_back('{x + 10, 4'b0100, 4'b0000});
    wait_cyc(x + 10); chk("a_ch2_lvlf_down", lf_a, 4'b0000);
    wait_cyc(x + 12); chk("a_ch2_pend", pend_a, 4'b0100);
    clr_a = 4'b0100;
    wait_cyc(x + 13); clr_a = 4'b0000;

    // A: ch1 and ch3 rise together. A clear in the tick cycle loses to the set.
    x = cyc; level_a = 4'b1010;
    q_a.push_back('{x + 4, 4'b1010, 4'b1010});
    wait_cyc(x + 4); clr_a = 4'b1000;
    wait_cyc(x + 5); clr_a = 4'b0000;
    chk("a_pend_set_wins", pend_a, 4'b1010); chk("a_any_two", any_a, 1);
    wait_cyc(x + 7); clr_a = 4'b1000;
    wait_cyc(x + 8); clr_a = 4'b0000;
    chk("a_pend_clr3", pend_a, 4'b0010); chk("a_any_one_left", any_a, 1);
    clr_a = 4'b0010;
    wait_cyc(x + 9); clr_a = 4'b0000;
    chk("a_pend_clr1", pend_a, 0); chk("a_any_none", any_a, 0);

    // A: all four channels change at once with mode 11. There are two rises and two falls.
    mode_a = 8'hFF;
    x = cyc; level_a = 4'b0101;
    q_a.push_back('{x + 4, 4'b1111, 4'b0101});
    wait_cyc(x + 5); chk("a_pend_all", pend_a, 4'b1111);
    clr_a = 4'b1111;
    wait_cyc(x + 6); clr_a = 4'b0000; chk("a_pend_all_clr", pend_a, 0);

    // Park A: mode 00 masks ticks while the shared resets below are exercised.
    mode_a = 8'h00; level_a = 4'h0;
    wait_cyc(x + 12);

    // B (DEB=4): a 3-cycle glitch on ch1 is discarded.
    x = cyc; level_b[1] = 1'b1;
    wait_cyc(x + 3); level_b[1] = 1'b0;
    wait_cyc(x + 14); chk("b_glitch_lvlf", lf_b, 0); chk("b_glitch_pend", pend_b, 0);

    // B: a sustained high gives a rising tick at latency 1+2+4 = 7, and a later low gives a falling tick.
    x = cyc; level_b[1] = 1'b1;
    q_b.push_back('{x + 7, 4'b0010, 4'b0010});
    wait_cyc(x + 6); chk("b_lvlf_before", lf_b, 0);
    wait_cyc(x + 7); chk("b_lvlf_up", lf_b, 4'b0010);
    wait_cyc(x + 10); level_b[1] = 1'b0;
    q_b.push_back('{x + 17, 4'b0010, 4'b0000});
    wait_cyc(x + 20); chk("b_lvlf_down", lf_b, 0); chk("b_pend", pend_b, 4'b0010);
    clr_b = 4'b0010;
    wait_cyc(x + 21); clr_b = 4'b0000; chk("b_pend_clr", pend_b, 0);

    // B: inputs held high through reset release. All four channels rise together.
    mode_b = 8'h55; level_b = 4'hF; reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("b_rst_hi_lvlf", lf_b, 0); chk("b_rst_hi_pend", pend_b, 0);
    x = cyc; reset = 1'b0;
    q_b.push_back('{x + 7, 4'b1111, 4'b1111});
    wait_cyc(x + 6); chk("b_rel_lvlf_before", lf_b, 0);
    wait_cyc(x + 7);
    // A reset asserted mid-tick drops tick and level_f at once.
    #2 reset = 1'b1;
    #1 chk("b_abort_tick", tick_b, 0); chk("b_abort_lvlf", lf_b, 0);
    chk("b_abort_pend", pend_b, 0); chk("b_abort_any", any_b, 0);

    // Release again with the inputs still high. The channels rise again, then a reset mid-debounce follows.
    @(negedge clk); x = cyc; reset = 1'b0;
    q_b.push_back('{x + 7, 4'b1111, 4'b1111});
    wait_cyc(x + 8); chk("b_pend_again", pend_b, 4'b1111); level_b = 4'h0;
    wait_cyc(x + 12);
    #1 reset = 1'b1;
    #1 chk("b_middeb_lvlf", lf_b, 0); chk("b_middeb_pend", pend_b, 0);
    chk("b_middeb_any", any_b, 0); chk("b_middeb_tick", tick_b, 0);
    @(negedge clk); x = cyc; reset = 1'b0;
    wait_cyc(x + 15); chk("b_idle_lvlf", lf_b, 0); chk("b_idle_pend", pend_b, 0);

    chk("a_queue_drained", q_a.size(), 0);
    chk("b_queue_drained", q_b.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
